seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//   Display end of the digit-entry path: takes the four BCD digits x1..x4 from the
//   switch/button entry block and drives a 4-digit multiplexed common-anode 7-seg.
//   Time-multiplexes one digit per scan slot, with anti-ghost blanking, leading-zero
//   suppression, and blinking of the digit currently being edited.
// PARAMETERS
//   SCAN_DIV     120  clk cycles per digit slot (>=2)
//   BLINK_FRAMES 64   full 4-digit frames per blink half-period (>=1)
// PORTS
//   clk      in   1  system clock, all logic on posedge
//   rst      in   1  asynchronous, active-low reset
//   x1       in   4  digit shown on an[3] (leftmost, most significant)
//   x2       in   4  digit shown on an[2]
//   x3       in   4  digit shown on an[1]
//   x4       in   4  digit shown on an[0] (rightmost)
//   sel      in   4  edit select, same one-hot coding as entry switches: bit0=x1..bit3=x4
//   blank_lz in   1  1 = suppress leading zeros
//   an       out  4  digit enables, active-low
//   seg      out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp       out  1  decimal point, active-low; held 1 (off)
// BEHAVIOUR
//   Reset (rst=0, async): an=4'b1111, seg=7'h7F, dp=1, prescaler=0, slot idx=0,
//     blink counter=0, blink phase=0, shadow digits=0. All outputs registered.
//   Prescaler: counts 0..SCAN_DIV-1, wraps; tick asserted for one clk when value=SCAN_DIV-1.
//   On tick edge: idx <= idx+1 mod 4 (0->1->2->3->0); an <= 4'b1111 (dead cycle).
//   Cycle after tick: an <= one-hot-low for idx (idx0->an[3] ... idx3->an[0]), seg for it.
//     Digit is lit SCAN_DIV-1 cycles per slot; a frame is 4*SCAN_DIV cycles.
//   Shadow capture: x1..x4, sel, blank_lz sampled into shadow regs on the tick edge where
//     idx wraps 3->0; mid-frame input changes never appear before next frame.
//   Decode (value v): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//     6=0000010 7=1111000 8=0000000 9=0010000; v>=10 -> dash 0111111.
//   Blink: counter counts frames (idx wrap) 0..BLINK_FRAMES-1; at wrap phase toggles.
//     Digit k blanked (seg=7'h7F, an still enabled) when shadow sel==one-hot k and phase=1.
//     sel not exactly one-hot (0000, multi-bit) -> no blinking.
//   Leading-zero blank (shadow blank_lz=1): x1 blank if x1==0; x2 blank if x1==0&&x2==0;
//     x3 blank if x1..x3 all 0; x4 never blanked. The selected (edited) digit is exempt.
//   Priority per slot: blink-off > LZ blank > decode.
//   Reset mid-frame: outputs go to reset values immediately; scan restarts at idx0
//     first lit SCAN_DIV cycles after reset release (shadow=0 until first frame wrap).
//   Input widths: x* are 4-bit; no arithmetic on them, only decode.
// TESTING
//   Reset: hold rst=0 random inputs -> an=1111, seg=7F, dp=1; release -> an=1111 until first tick.
//   Scan (SCAN_DIV=4): x=1,2,3,4 after one frame -> an 0111/1011/1101/1110 in order, each 3 clk
//     lit after 1 clk all-high, seg 1111001,0100100,0110000,0011001.
//   Invalid/LZ: x=0,0,0xB,0, blank_lz=1, sel=0 -> an[3],an[2] slots seg=7F, an[1] dash 0111111,
//     an[0] 1000000; blank_lz=0 -> zeros shown.
//   Blink (BLINK_FRAMES=2): sel=0100, x3=7 -> an[1] slot 1111000 for 2 frames, 7F for 2 frames;
//     sel=0110 -> steady 1111000.
//   Tearing: change x2 5->6 during idx2 slot -> 6 appears only from next frame's idx1 slot.
//   Reset mid-slot: assert rst during idx2 lit -> same cycle an=1111; restart at idx0 slot.

Source files
------------

// File: rtl/seg7_scan_display_if.sv
// Purpose: digit-entry to display bus; digits, edit select and LZ control in, scan outputs back.
// Latency: none, plain wires.
// Backpressure: none, display side samples continuously.
interface seg7_scan_display_if;
   logic [3:0] x1;
   logic [3:0] x2;
   logic [3:0] x3;
   logic [3:0] x4;
   logic [3:0] sel;
   logic       blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   // entry side: drives digits and controls, observes the panel drive
   modport master (
      output x1, x2, x3, x4, sel, blank_lz,
      input  an, seg, dp
   );

   // display side: consumes digits, drives the panel
   modport slave (
      input  x1, x2, x3, x4, sel, blank_lz,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Purpose: 4-digit multiplexed common-anode 7-seg driver with blanking, LZ suppress, edit blink.
// Latency: inputs shadowed at frame start; a digit lights one dead cycle after its slot tick.
// Backpressure: none; inputs are sampled once per frame and may change freely at any time.
module seg7_scan_display #(
   parameter int SCAN_DIV     = 120,
   parameter int BLINK_FRAMES = 64
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_display_if.slave dbus
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   // WAIT only exists between reset release and the first tick, so the
   // first lit slot after reset is idx0 rather than idx1.
   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_DEAD = 2'd1,
      ST_LIT  = 2'd2
   } scan_state_t;

   scan_state_t   state;
   scan_state_t   state_nxt;
   logic [PW-1:0] presc;
   logic          tick;
   logic          slot_adv;
   logic          frame_wrap;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [3:0]    sh_x [4];
   logic [3:0]    sh_sel;
   logic          sh_lz;
   logic [3:0]    cur_v;
   logic          sel_oh;
   logic          edit;
   logic          lead_zero;
   logic [6:0]    pix;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;   // non-BCD shows a dash
      endcase
      return s;
   endfunction

   assign tick       = (presc == PRESC_MAX);
   assign slot_adv   = tick && (state != ST_WAIT);
   assign frame_wrap = slot_adv && (idx == 2'd3);

   // free-running slot prescaler
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) presc <= '0;
      else      presc <= tick ? '0 : presc + PW'(1);
   end

   // slot index advances on every tick once scanning has started
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          idx <= 2'd0;
      else if (slot_adv) idx <= idx + 2'd1;
   end

   // shadow capture at frame start keeps a whole frame consistent
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_x[0] <= 4'd0;
         sh_x[1] <= 4'd0;
         sh_x[2] <= 4'd0;
         sh_x[3] <= 4'd0;
         sh_sel  <= 4'd0;
         sh_lz   <= 1'b0;
      end else if (frame_wrap) begin
         sh_x[0] <= dbus.x1;
         sh_x[1] <= dbus.x2;
         sh_x[2] <= dbus.x3;
         sh_x[3] <= dbus.x4;
         sh_sel  <= dbus.sel;
         sh_lz   <= dbus.blank_lz;
      end
   end

   // blink phase flips every BLINK_FRAMES frames
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (frame_wrap) begin
         if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // pattern for the current slot: blink-off beats LZ blank beats decode
   always_comb begin
      cur_v     = sh_x[idx];
      sel_oh    = (sh_sel == 4'b0001) || (sh_sel == 4'b0010) ||
                  (sh_sel == 4'b0100) || (sh_sel == 4'b1000);
      edit      = sel_oh && sh_sel[idx];
      lead_zero = 1'b0;
      case (idx)
         2'd0:    lead_zero = (sh_x[0] == 4'd0);
         2'd1:    lead_zero = (sh_x[0] == 4'd0) && (sh_x[1] == 4'd0);
         2'd2:    lead_zero = (sh_x[0] == 4'd0) && (sh_x[1] == 4'd0) && (sh_x[2] == 4'd0);
         default: lead_zero = 1'b0;   // rightmost digit always shown
      endcase
      pix = seg_decode(cur_v);
      if (edit && blink_ph)                 pix = 7'h7F;
      else if (sh_lz && !edit && lead_zero) pix = 7'h7F;
   end

   // scan state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_WAIT;
      else      state <= state_nxt;
   end

   // next state and next panel drive; every tick forces one all-off cycle
   always_comb begin
      state_nxt = state;
      an_nxt    = 4'b1111;
      seg_nxt   = 7'h7F;
      case (state)
         ST_WAIT: begin
            if (tick) state_nxt = ST_DEAD;
         end
         ST_DEAD: begin
            state_nxt = ST_LIT;
            an_nxt    = ~(4'b1000 >> idx);
            seg_nxt   = pix;
         end
         ST_LIT: begin
            if (tick) begin
               state_nxt = ST_DEAD;
            end else begin
               an_nxt  = ~(4'b1000 >> idx);
               seg_nxt = pix;
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // registered panel outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q  <= 4'b1111;
         seg_q <= 7'h7F;
      end else begin
         an_q  <= an_nxt;
         seg_q <= seg_nxt;
      end
   end

   assign dbus.an  = an_q;
   assign dbus.seg = seg_q;
   assign dbus.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Purpose: randomized + directed bench for seg7_scan_display against a time-based reference.
// Latency: model derives slot/frame from cycles since reset release.
// Backpressure: n/a.
module tb_seg7_scan_display;
   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FRAME = 4 * SD;

   logic clk = 1'b0;
   logic rst;

   seg7_scan_display_if dbus ();

   seg7_scan_display #(
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .dbus (dbus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // reference: cycles since release, plus inputs seen at each frame start
   int         t;
   logic [3:0] m_x [4];
   logic [3:0] m_sel;
   logic       m_lz;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         t <= 0;
         for (int i = 0; i < 4; i++) m_x[i] <= 4'd0;
         m_sel <= 4'd0;
         m_lz  <= 1'b0;
      end else begin
         t <= t + 1;
         if ((t + 1) > SD && ((t + 1 - SD) % FRAME) == 0) begin
            m_x[0] <= dbus.x1;
            m_x[1] <= dbus.x2;
            m_x[2] <= dbus.x3;
            m_x[3] <= dbus.x4;
            m_sel  <= dbus.sel;
            m_lz   <= dbus.blank_lz;
         end
      end
   end

   function automatic void model_out(output logic [3:0] e_an, output logic [6:0] e_seg);
      int   k, d, f;
      logic oh, edit, allz;
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      if (rst === 1'b1 && t > SD) begin
         k = t - SD;
         if ((k % SD) != 0) begin
            d     = (k / SD) % 4;
            f     = (k / SD) / 4;
            e_an  = ~(4'b1000 >> d);
            oh    = (m_sel == 4'd1) || (m_sel == 4'd2) || (m_sel == 4'd4) || (m_sel == 4'd8);
            edit  = oh && m_sel[d];
            allz  = 1'b1;
            for (int i = 0; i <= d; i++) if (m_x[i] != 4'd0) allz = 1'b0;
            if (edit && ((f / BF) % 2) == 1)      e_seg = 7'h7F;
            else if (m_lz && !edit && d < 3 && allz) e_seg = 7'h7F;
            else if (m_x[d] < 4'd10)              e_seg = dec_tab[m_x[d]];
            else                                   e_seg = 7'b0111111;
         end
      end
   endfunction

   logic chk_en = 1'b0;

   // every cycle compare the panel against the reference
   always @(negedge clk) begin
      logic [3:0] e_an;
      logic [6:0] e_seg;
      if (chk_en) begin
         model_out(e_an, e_seg);
         check("an", 32'(dbus.an), 32'(e_an));
         check("seg", 32'(dbus.seg), 32'(e_seg));
         check("dp", 32'(dbus.dp), 32'd1);
      end
   end

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] s, input logic lz);
      @(posedge clk);
      #2;
      dbus.x1 = a; dbus.x2 = b; dbus.x3 = c; dbus.x4 = d;
      dbus.sel = s; dbus.blank_lz = lz;
   endtask

   task automatic drive_rand();
      logic [3:0] v [4];
      logic [3:0] s;
      for (int i = 0; i < 4; i++)
         v[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 1) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive(v[0], v[1], v[2], v[3], s, 1'($urandom_range(0, 1)));
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic wait_an(input logic [3:0] v);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dbus.an == v) break;
      end
      check("wait_an", 32'(dbus.an), 32'(v));
   endtask

   initial begin
      rst = 1'b1;
      dbus.x1 = 4'd0; dbus.x2 = 4'd0; dbus.x3 = 4'd0; dbus.x4 = 4'd0;
      dbus.sel = 4'd0; dbus.blank_lz = 1'b0;
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // reset held with changing inputs
      repeat (5) drive_rand();
      @(negedge clk);
      check("rst_an", 32'(dbus.an), 32'hF);
      check("rst_seg", 32'(dbus.seg), 32'h7F);

      // release, then normal scan of 1,2,3,4
      drive(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0);
      rst = 1'b1;
      run(3 * FRAME);

      // invalid digit and leading-zero blanking, then LZ off
      drive(4'd0, 4'd0, 4'hB, 4'd0, 4'd0, 1'b1);
      run(2 * FRAME);
      drive(4'd0, 4'd0, 4'hB, 4'd0, 4'd0, 1'b0);
      run(2 * FRAME);

      // blink on x3, then multi-bit select means steady
      drive(4'd0, 4'd0, 4'd7, 4'd0, 4'b0100, 1'b0);
      run(5 * FRAME);
      drive(4'd0, 4'd0, 4'd7, 4'd0, 4'b0110, 1'b0);
      run(2 * FRAME);

      // tearing: x2 changes during the idx2 slot
      drive(4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
      run(2 * FRAME);
      wait_an(4'b1101);
      drive(4'd0, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0);
      wait_an(4'b1011);
      check("tear_x2", 32'(dbus.seg), 32'(7'b0000010));
      run(FRAME);

      // reset in the middle of a lit slot
      wait_an(4'b1101);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_an", 32'(dbus.an), 32'hF);
      check("midrst_seg", 32'(dbus.seg), 32'h7F);
      run(3);
      @(posedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dbus.an != 4'b1111) break;
      end
      check("restart_idx0", 32'(dbus.an), 32'(4'b0111));
      run(2 * FRAME);

      // random inputs with occasional reset pulses
      for (int it = 0; it < 60; it++) begin
         drive_rand();
         if ($urandom_range(0, 11) == 0) begin
            @(posedge clk);
            #2 rst = 1'b0;
            run($urandom_range(1, 3));
            @(posedge clk);
            #2 rst = 1'b1;
         end
         run($urandom_range(1, 40));
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
